// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO, one word per frame.
// Frame: start bit, data LSB first, optional parity, one or two stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_val,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         baud_q;
    logic [BW-1:0]         bit_q;
    logic                  stop_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_q;
    logic                  tx_q;

    logic                  baudEnd;
    logic                  lastStop;
    logic                  popReq;
    logic [BW-1:0]         bitNext;

    assign baudEnd  = (baud_q == BAUD_LAST);
    assign lastStop = (state_q == STOP) && baudEnd && (stop_q == STOP_LAST);
    // The pop is gated by reset so an aborted frame never consumes a word.
    assign popReq   = !reset && enable && fifo_val && ((state_q == IDLE) || lastStop);
    assign bitNext  = bit_q + BW'(1);

    assign fifo_read  = popReq;
    assign frame_done = lastStop;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else if (popReq) begin
            shift_q  <= fifo_data;
            parity_q <= (^fifo_data) ^ ODD;
            state_q  <= START;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b0;
        end else begin
            if (state_q != IDLE && !baudEnd) begin
                baud_q <= baud_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                end
                START: begin
                    if (baudEnd) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baudEnd) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bitNext;
                            tx_q  <= shift_q[bitNext];
                        end
                    end
                end
                PARITY: begin
                    if (baudEnd) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (baudEnd) begin
                        baud_q <= '0;
                        if (stop_q == STOP_LAST) begin
                            stop_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Consumer stage placed directly downstream of the team's ring FIFO.
- Pops one word at a time through the FIFO's show-ahead interface (data/val in, read pulse out).
- Serialises each word as an asynchronous UART frame: start bit, data LSB first, optional parity, stop bit(s).
- Drives the board TX pin and reports busy and frame-complete status to control logic.

Parameters:
DATA_WIDTH, 8, width of each FIFO word and number of data bits per frame
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = new frames may start; 0 = hold in idle after the current frame
fifo_data  input  DATA_WIDTH  FIFO head word, valid while fifo_val = 1
fifo_val  input  1  FIFO non-empty
fifo_read  output  1  one-cycle pop request for the FIFO head
tx  output  1  serial line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse in the final stop-bit cycle

Behaviour:
- Clocking and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: tx=1, busy=0, frame_done=0, fifo_read=0, state IDLE, counters 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately: tx returns high asynchronously and no pop is issued.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE or START.
- Bit timing: baud counter counts 0..CLKS_PER_BIT-1. Each state bit lasts exactly CLKS_PER_BIT cycles.
- DATA uses a bit index 0..DATA_WIDTH-1. STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
- Pop condition: fifo_read = enable & fifo_val & (state==IDLE | final STOP cycle). It is combinational from registered state and is never asserted in any other cycle.
- Capture: on the edge ending a fifo_read cycle, latch fifo_data into the shift register, compute parity (XOR of data bits, inverted if PARITY_ODD), and enter START.
- Latency: tx falls to 0 the cycle after fifo_read is asserted. tx is registered and glitch-free.
- Line levels: START drives tx=0. DATA drives shift_reg[bit index], LSB first. PARITY drives the parity bit. STOP drives tx=1.
- Back-to-back frames: if the pop condition holds in the final STOP cycle, the next START follows with no idle gap.
- busy = 1 in every non-IDLE state; it stays 1 across back-to-back frames.
- frame_done = 1 only in the final STOP cycle, whether or not a new pop occurs.
- enable deasserted mid-frame: the current frame completes normally; no further pop.
- fifo_val dropping mid-frame has no effect, because data is already latched.
- fifo_data changes after capture are ignored.
- No pop while fifo_val = 0, even in IDLE with enable = 1.
- At most one pop per frame. The earliest re-sample of fifo_val is DATA_WIDTH+2 bit times after the previous pop, so the FIFO always has time to update val.

Test Plan:
- Idle/reset (CLKS_PER_BIT=4): hold reset, then release with fifo_val=0 -> tx=1, busy=0, fifo_read never asserted for 50 cycles.
- Single byte 0xA5 (CLKS_PER_BIT=4, no parity): enable=1, fifo_val=1 for one pop -> fifo_read high exactly 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_done pulses at cycle 40 after the pop; busy falls the next cycle.
- Back-to-back 0x01, 0xFF with fifo_val held high -> second fifo_read coincides with the frame_done of the first frame; no idle cycle between the stop bit and the second start bit; exactly 2 pops.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0. Frame length is 11 bit times.
- enable drop: deassert enable during data bit 3 -> frame completes intact, no further pop while fifo_val=1; re-assert enable -> pop within 1 cycle.
- Reset mid-frame: assert reset during data bit 5 -> tx=1 in the same cycle (asynchronous), busy=0; after release, the next pop starts a full fresh frame.
